// File: rtl/cg_pkg.sv
// rtl/cg_pkg.sv - shared types and constants for the conjugate-gradient address sequencer
package cg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRELOAD = 2'd1,
        ST_RUN     = 2'd2,
        ST_HALTED  = 2'd3
    } cg_state_t;

    localparam int CG_ADDR_W = 32;
    localparam int CG_LANES  = 8;

    // Floor of log2; LANES is a power of two so this is the exact shift amount
    function automatic int cg_log2(input int value);
        int result;
        result = 0;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) <= value) result = i;
        end
        return result;
    endfunction

endpackage

// File: rtl/cg_wrap_counter.sv
// rtl/cg_wrap_counter.sv - address counter that wraps to zero when it would reach limit
module cg_wrap_counter
    import cg_pkg::*;
#(
    parameter int ADDR_W = CG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic [ADDR_W-1:0] limit,
    output logic [ADDR_W-1:0] value,
    output logic              wrap
);

    logic [ADDR_W-1:0] next_val;

    assign next_val = value + ADDR_W'(1);

    // Clear beats load beats increment; wrap is high for the one cycle after a wrap-around
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
            wrap  <= 1'b0;
        end else if (clr) begin
            value <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            value <= load_val;
            wrap  <= 1'b0;
        end else if (en) begin
            if (next_val == limit) begin
                value <= '0;
                wrap  <= 1'b1;
            end else begin
                value <= next_val;
                wrap  <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/cg_addr_sequencer.sv
// rtl/cg_addr_sequencer.sv - address and iteration sequencer for the conjugate-gradient datapath
module cg_addr_sequencer
    import cg_pkg::*;
#(
    parameter int ADDR_W      = CG_ADDR_W,
    parameter int LANES       = CG_LANES,
    parameter int NUM_CH      = 4,
    parameter int ITER_W      = 11,
    parameter int FINISH_HOLD = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              total,
    input  logic [ITER_W-1:0]        max_iter,
    input  logic                     start,
    input  logic                     pre_process,
    input  logic [NUM_CH-1:0]        rd_adv,
    input  logic [NUM_CH-1:0]        wr_req,
    input  logic [NUM_CH-1:0]        wr_idx_mode,
    input  logic [NUM_CH*ADDR_W-1:0] wr_idx,
    input  logic                     finish_alu,
    input  logic                     finish_all,
    output logic [ADDR_W-1:0]        a_rd_addr,
    output logic [NUM_CH*ADDR_W-1:0] rd_addr,
    output logic [NUM_CH*ADDR_W-1:0] wr_addr,
    output logic [NUM_CH-1:0]        wr_en,
    output logic [NUM_CH-1:0]        rd_wrap,
    output logic [ITER_W-1:0]        iteration,
    output logic                     busy,
    output logic                     halt,
    output logic                     overrun
);

    localparam int LOG2_LANES = cg_log2(LANES);
    localparam int HOLD_W     = $clog2(FINISH_HOLD + 1);

    cg_state_t         state_q;
    cg_state_t         state_d;
    logic [ADDR_W-1:0] depth_q;
    logic [ITER_W-1:0] max_iter_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [ADDR_W-1:0] start_depth;
    logic [ITER_W-1:0] iter_inc;
    logic              start_ok;
    logic              run_act;
    logic              alu_clr;
    logic              adv_ok;
    logic              hold_hit;
    logic              limit_hit;

    assign start_depth = ADDR_W'(total >> LOG2_LANES);
    assign start_ok    = start && (state_q == ST_IDLE || state_q == ST_HALTED);
    // finish_all pre-empts every other RUN activity on its edge
    assign run_act     = (state_q == ST_RUN) && !finish_all;
    assign alu_clr     = run_act && finish_alu;
    assign adv_ok      = run_act && !finish_alu;
    assign hold_hit    = alu_clr && (hold_cnt_q == HOLD_W'(FINISH_HOLD - 1));
    assign iter_inc    = (&iteration) ? iteration : iteration + 1'b1;
    assign limit_hit   = hold_hit && (max_iter_q != '0) && (iter_inc == max_iter_q);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    if (start_depth == '0) state_d = ST_HALTED;
                    else if (pre_process)  state_d = ST_PRELOAD;
                    else                   state_d = ST_RUN;
                end
            end
            ST_PRELOAD: if (!pre_process) state_d = ST_RUN;
            ST_RUN:     if (finish_all || limit_hit) state_d = ST_HALTED;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy = 1'b0;
        if (state_q == ST_PRELOAD || state_q == ST_RUN) busy = 1'b1;
    end

    // Run parameters, matrix-A pointer, finish hold counter, iteration and sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_q    <= '0;
            max_iter_q <= '0;
            hold_cnt_q <= '0;
            iteration  <= '0;
            halt       <= 1'b0;
            overrun    <= 1'b0;
            a_rd_addr  <= '0;
        end else if (start_ok) begin
            depth_q    <= start_depth;
            max_iter_q <= max_iter;
            hold_cnt_q <= '0;
            iteration  <= '0;
            halt       <= (start_depth == '0);
            overrun    <= 1'b0;
            a_rd_addr  <= '0;
        end else begin
            if (state_q == ST_PRELOAD && pre_process) a_rd_addr <= a_rd_addr + 1'b1;
            else if (alu_clr)                         a_rd_addr <= '0;

            if (state_q == ST_RUN) begin
                if (finish_all) begin
                    iteration  <= iter_inc;
                    halt       <= 1'b1;
                    hold_cnt_q <= '0;
                end else if (finish_alu) begin
                    // Count saturates so a long high run yields one boundary only
                    if (hold_cnt_q != HOLD_W'(FINISH_HOLD)) hold_cnt_q <= hold_cnt_q + 1'b1;
                    if (hold_hit) begin
                        iteration <= iter_inc;
                        if (limit_hit) halt <= 1'b1;
                    end
                    if (|wr_req) overrun <= 1'b1;
                end else begin
                    hold_cnt_q <= '0;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ADDR_W-1:0] idx;
        logic [ADDR_W-1:0] wr_ptr;
        logic [ADDR_W-1:0] wr_addr_q;
        logic              wr_en_q;
        logic              wr_ptr_wrap_unused;

        assign idx = wr_idx[c*ADDR_W +: ADDR_W];

        cg_wrap_counter #(.ADDR_W(ADDR_W)) u_rd_cnt (
            .clk      (clk),
            .reset    (reset),
            .en       (adv_ok && rd_adv[c]),
            .clr      (alu_clr || start_ok),
            .load     (1'b0),
            .load_val ('0),
            .limit    (depth_q),
            .value    (rd_addr[c*ADDR_W +: ADDR_W]),
            .wrap     (rd_wrap[c])
        );

        cg_wrap_counter #(.ADDR_W(ADDR_W)) u_wr_cnt (
            .clk      (clk),
            .reset    (reset),
            .en       (adv_ok && wr_req[c] && !wr_idx_mode[c]),
            .clr      (alu_clr || start_ok),
            .load     (1'b0),
            .load_val ('0),
            .limit    (depth_q),
            .value    (wr_ptr),
            .wrap     (wr_ptr_wrap_unused)
        );

        // Registered write strobe and address; out-of-range explicit indices are dropped
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_addr_q <= '0;
                wr_en_q   <= 1'b0;
            end else if (alu_clr || start_ok) begin
                wr_addr_q <= '0;
                wr_en_q   <= 1'b0;
            end else if (adv_ok && wr_req[c]) begin
                if (!wr_idx_mode[c]) begin
                    wr_addr_q <= wr_ptr;
                    wr_en_q   <= 1'b1;
                end else if (idx < depth_q) begin
                    wr_addr_q <= idx;
                    wr_en_q   <= 1'b1;
                end else begin
                    wr_en_q   <= 1'b0;
                end
            end else begin
                wr_en_q <= 1'b0;
            end
        end

        assign wr_addr[c*ADDR_W +: ADDR_W] = wr_addr_q;
        assign wr_en[c]                    = wr_en_q;
    end

endmodule

// File: tb/tb_cg_addr_sequencer.sv
// tb/tb_cg_addr_sequencer.sv - self-checking bench for cg_addr_sequencer
module tb_cg_addr_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  total;
    logic [10:0]  max_iter;
    logic         start;
    logic         pre_process;
    logic [3:0]   rd_adv;
    logic [3:0]   wr_req;
    logic [3:0]   wr_idx_mode;
    logic [127:0] wr_idx;
    logic         finish_alu;
    logic         finish_all;
    logic [31:0]  a_rd_addr;
    logic [127:0] rd_addr;
    logic [127:0] wr_addr;
    logic [3:0]   wr_en;
    logic [3:0]   rd_wrap;
    logic [10:0]  iteration;
    logic         busy;
    logic         halt;
    logic         overrun;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] addr;
    } wr_exp_t;

    wr_exp_t wr_q[$];
    wr_exp_t mon_e;
    int      n_checks = 0;
    int      n_fail   = 0;
    int      wraps;
    int      idx_list[4] = '{5, 7, 8, 9};

    cg_addr_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .total       (total),
        .max_iter    (max_iter),
        .start       (start),
        .pre_process (pre_process),
        .rd_adv      (rd_adv),
        .wr_req      (wr_req),
        .wr_idx_mode (wr_idx_mode),
        .wr_idx      (wr_idx),
        .finish_alu  (finish_alu),
        .finish_all  (finish_all),
        .a_rd_addr   (a_rd_addr),
        .rd_addr     (rd_addr),
        .wr_addr     (wr_addr),
        .wr_en       (wr_en),
        .rd_wrap     (rd_wrap),
        .iteration   (iteration),
        .busy        (busy),
        .halt        (halt),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every observed write must match the oldest expected write
    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < 4; c++) begin
                if (wr_en[c]) begin
                    if (wr_q.size() == 0) begin
                        check_eq("wr_unexpected", 64'(wr_en[c]), 64'd0);
                    end else begin
                        mon_e = wr_q.pop_front();
                        check_eq("wr_ch", 64'(c), 64'(mon_e.ch));
                        check_eq("wr_addr", 64'(wr_addr[c*32 +: 32]), 64'(mon_e.addr));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; total = '0; max_iter = '0; start = 1'b0; pre_process = 1'b0;
        rd_adv = '0; wr_req = '0; wr_idx_mode = '0; wr_idx = '0;
        finish_alu = 1'b0; finish_all = 1'b0;
        repeat (2) tick();
        check_eq("rst_a_rd_addr", 64'(a_rd_addr), 64'd0);
        check_eq("rst_rd_addr", 64'(rd_addr != '0), 64'd0);
        check_eq("rst_wr_addr", 64'(wr_addr != '0), 64'd0);
        check_eq("rst_wr_en", 64'(wr_en), 64'd0);
        check_eq("rst_iter", 64'(iteration), 64'd0);
        check_eq("rst_flags", 64'({busy, halt, overrun}), 64'd0);
        reset = 1'b0;
        tick();

        // Read channel 0 wraps at depth 8
        total = 32'd64; max_iter = '0; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t1_busy", 64'(busy), 64'd1);
        rd_adv = 4'b0001;
        wraps = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            check_eq("t1_rd_addr0", 64'(rd_addr[31:0]), 64'((i + 1) % 8));
            check_eq("t1_rd_wrap0", 64'(rd_wrap[0]), 64'(i == 7));
            wraps += int'(rd_wrap[0]);
        end
        rd_adv = '0;
        check_eq("t1_wrap_count", 64'(wraps), 64'd1);

        // Auto-increment writes, then explicit indices around the depth boundary
        wr_req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            wr_q.push_back('{ch: 2'd1, addr: 32'(i)});
            tick();
        end
        wr_req = '0;
        tick();
        wr_idx_mode = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            wr_idx[63:32] = 32'(idx_list[k]);
            wr_req = 4'b0010;
            if (idx_list[k] < 8) wr_q.push_back('{ch: 2'd1, addr: 32'(idx_list[k])});
            tick();
            check_eq("t2_wr_en1", 64'(wr_en[1]), 64'(idx_list[k] < 8));
            wr_req = '0;
            tick();
        end
        wr_idx_mode = '0;
        wr_req = 4'b0010;
        wr_q.push_back('{ch: 2'd1, addr: 32'd3});
        tick();
        wr_req = '0;
        tick();

        // finish_alu collides with a write and a read advance
        finish_alu = 1'b1; wr_req = 4'b0100; rd_adv = 4'b0001;
        tick();
        finish_alu = 1'b0; wr_req = '0; rd_adv = '0;
        check_eq("t4_rd_addr", 64'(rd_addr != '0), 64'd0);
        check_eq("t4_wr_addr", 64'(wr_addr != '0), 64'd0);
        check_eq("t4_wr_en", 64'(wr_en), 64'd0);
        check_eq("t4_overrun", 64'(overrun), 64'd1);
        check_eq("t4_a_rd_addr", 64'(a_rd_addr), 64'd0);
        tick();
        check_eq("t4_iter_short", 64'(iteration), 64'd0);
        check_eq("t4_overrun_sticky", 64'(overrun), 64'd1);
        rd_adv = 4'b0001;
        repeat (2) tick();
        rd_adv = '0;
        check_eq("t4_rd_after_clr", 64'(rd_addr[31:0]), 64'd2);

        // finish_all stops at once and counts an iteration
        finish_all = 1'b1;
        tick();
        finish_all = 1'b0;
        check_eq("t6_fa_iter", 64'(iteration), 64'd1);
        check_eq("t6_fa_halt", 64'(halt), 64'd1);
        check_eq("t6_fa_busy", 64'(busy), 64'd0);
        rd_adv = 4'b0001; wr_req = 4'b0001; finish_alu = 1'b1; pre_process = 1'b1;
        repeat (5) tick();
        rd_adv = '0; wr_req = '0; finish_alu = 1'b0; pre_process = 1'b0;
        check_eq("halted_rd_hold", 64'(rd_addr[31:0]), 64'd2);
        check_eq("halted_iter_hold", 64'(iteration), 64'd1);
        check_eq("halted_a_hold", 64'(a_rd_addr), 64'd0);

        // Iteration limit of 2 with short and long finish_alu runs
        max_iter = 11'd2; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t3_restart_iter", 64'(iteration), 64'd0);
        check_eq("t3_restart_flags", 64'({busy, halt, overrun}), 64'b100);
        finish_alu = 1'b1;
        repeat (3) tick();
        finish_alu = 1'b0;
        tick();
        check_eq("t3_short_run", 64'(iteration), 64'd0);
        finish_alu = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("t3_long_run", 64'(iteration), 64'(i >= 3));
        end
        finish_alu = 1'b0;
        tick();
        check_eq("t3_not_halted", 64'({busy, halt}), 64'b10);
        finish_alu = 1'b1;
        repeat (4) tick();
        finish_alu = 1'b0;
        check_eq("t3_iter_limit", 64'(iteration), 64'd2);
        check_eq("t3_halt", 64'(halt), 64'd1);
        check_eq("t3_busy", 64'(busy), 64'd0);

        // Matrix-A preload then asynchronous reset mid-RUN
        pre_process = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t5_preload_busy", 64'(busy), 64'd1);
        repeat (10) tick();
        check_eq("t5_a_rd_addr", 64'(a_rd_addr), 64'd10);
        pre_process = 1'b0;
        tick();
        check_eq("t5_a_hold", 64'(a_rd_addr), 64'd10);
        check_eq("t5_run_busy", 64'(busy), 64'd1);
        rd_adv = 4'b1000;
        repeat (3) tick();
        rd_adv = '0;
        check_eq("t5_rd_addr3", 64'(rd_addr[127:96]), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t5_rst_a", 64'(a_rd_addr), 64'd0);
        check_eq("t5_rst_rd", 64'(rd_addr != '0), 64'd0);
        check_eq("t5_rst_wr", 64'({wr_addr != '0, wr_en, rd_wrap}), 64'd0);
        check_eq("t5_rst_iter", 64'(iteration), 64'd0);
        check_eq("t5_rst_flags", 64'({busy, halt, overrun}), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // Zero depth halts immediately; a valid restart from HALTED runs
        total = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t6_depth0_halt", 64'(halt), 64'd1);
        check_eq("t6_depth0_busy", 64'(busy), 64'd0);
        rd_adv = 4'b0001;
        tick();
        rd_adv = '0;
        check_eq("t6_depth0_rd", 64'(rd_addr[31:0]), 64'd0);
        total = 32'd64; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t6_restart", 64'({busy, halt}), 64'b10);

        repeat (2) tick();
        check_eq("sb_empty", 64'(wr_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
